// File: rtl/fifos_destino_d0_d1_if.sv
// Handshake bundle between the VC0/VC1 arbiter, the D0/D1 destination FIFOs and the consumer.
interface fifos_destino_d0_d1_if #(
  parameter int DATA_WIDTH = 6
);
  logic [DATA_WIDTH-1:0] arbitro_D0_out;
  logic [DATA_WIDTH-1:0] arbitro_D1_out;
  logic                  D0_push;
  logic                  D1_push;
  logic                  D0_pop;
  logic                  D1_pop;
  logic [DATA_WIDTH-1:0] D0_out;
  logic [DATA_WIDTH-1:0] D1_out;
  logic                  D0_valid;
  logic                  D1_valid;
  logic                  D0_pause;
  logic                  D1_pause;
  logic                  D0_empty;
  logic                  D1_empty;
  logic                  D0_full;
  logic                  D1_full;
  logic                  D0_almost_empty;
  logic                  D1_almost_empty;
  logic                  error_out;

  modport slave (
    input  arbitro_D0_out, arbitro_D1_out, D0_push, D1_push, D0_pop, D1_pop,
    output D0_out, D1_out, D0_valid, D1_valid, D0_pause, D1_pause,
           D0_empty, D1_empty, D0_full, D1_full, D0_almost_empty, D1_almost_empty,
           error_out
  );

  modport master (
    output arbitro_D0_out, arbitro_D1_out, D0_push, D1_push, D0_pop, D1_pop,
    input  D0_out, D1_out, D0_valid, D1_valid, D0_pause, D1_pause,
           D0_empty, D1_empty, D0_full, D1_full, D0_almost_empty, D1_almost_empty,
           error_out
  );
endinterface

// File: rtl/fifos_destino_d0_d1.sv
// Two independent 8-deep destination FIFOs (D0, D1) with pause back-pressure,
// registered pop/valid read port and a shared sticky overflow/underflow flag.
module fifos_destino_d0_d1 #(
  parameter int DATA_WIDTH = 6,
  parameter int PTR_WIDTH  = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1
) (
  input  logic                   clk,
  input  logic                   reset_L,
  fifos_destino_d0_d1_if.slave   bus
);

  localparam int DEPTH = 2 ** PTR_WIDTH;
  localparam logic [PTR_WIDTH:0]   DEPTH_CNT = {1'b1, {PTR_WIDTH{1'b0}}};
  localparam logic [PTR_WIDTH:0]   AF_CNT    = (PTR_WIDTH + 1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0]   AE_CNT    = (PTR_WIDTH + 1)'(AE_THRESH);
  localparam logic [PTR_WIDTH:0]   ONE_CNT   = (PTR_WIDTH + 1)'(1);
  localparam logic [PTR_WIDTH-1:0] ONE_PTR   = PTR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] din_s      [2];
  logic [1:0]            push_s;
  logic [1:0]            pop_s;
  logic [1:0]            empty_s;
  logic [1:0]            full_s;
  logic [1:0]            pause_s;
  logic [1:0]            ae_s;
  logic [1:0]            push_acc_s;
  logic [1:0]            pop_acc_s;

  logic [DATA_WIDTH-1:0] mem_q      [2][DEPTH];
  logic [DATA_WIDTH-1:0] mem_d      [2][DEPTH];
  logic [PTR_WIDTH-1:0]  rd_ptr_q   [2];
  logic [PTR_WIDTH-1:0]  rd_ptr_d   [2];
  logic [PTR_WIDTH-1:0]  wr_ptr_q   [2];
  logic [PTR_WIDTH-1:0]  wr_ptr_d   [2];
  logic [PTR_WIDTH:0]    count_q    [2];
  logic [PTR_WIDTH:0]    count_d    [2];
  logic [DATA_WIDTH-1:0] out_q      [2];
  logic [DATA_WIDTH-1:0] out_d      [2];
  logic [1:0]            valid_q;
  logic [1:0]            valid_d;
  logic                  error_q;
  logic                  error_d;

  assign din_s[0]  = bus.arbitro_D0_out;
  assign din_s[1]  = bus.arbitro_D1_out;
  assign push_s    = {bus.D1_push, bus.D0_push};
  assign pop_s     = {bus.D1_pop,  bus.D0_pop};

  // Status flags and push/pop acceptance, derived from the stored count
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      empty_s[c]    = (count_q[c] == {(PTR_WIDTH + 1){1'b0}});
      full_s[c]     = (count_q[c] == DEPTH_CNT);
      pause_s[c]    = (count_q[c] >= AF_CNT);
      ae_s[c]       = (count_q[c] <= AE_CNT);
      pop_acc_s[c]  = pop_s[c] & ~empty_s[c];
      // A pop in the same cycle frees the slot, so a full FIFO can still take a push
      push_acc_s[c] = push_s[c] & (~full_s[c] | pop_acc_s[c]);
    end
  end

  // Next-state for pointers, count, read port, storage and the sticky error
  always_comb begin
    mem_d   = mem_q;
    error_d = error_q;
    valid_d = 2'b00;
    for (int c = 0; c < 2; c++) begin
      rd_ptr_d[c] = rd_ptr_q[c];
      wr_ptr_d[c] = wr_ptr_q[c];
      count_d[c]  = count_q[c];
      out_d[c]    = out_q[c];
      if (pop_acc_s[c]) begin
        out_d[c]    = mem_q[c][rd_ptr_q[c]];
        rd_ptr_d[c] = rd_ptr_q[c] + ONE_PTR;
        valid_d[c]  = 1'b1;
      end else begin
        valid_d[c]  = 1'b0;
      end
      if (push_acc_s[c]) begin
        mem_d[c][wr_ptr_q[c]] = din_s[c];
        wr_ptr_d[c]           = wr_ptr_q[c] + ONE_PTR;
      end else begin
        wr_ptr_d[c] = wr_ptr_q[c];
      end
      case ({push_acc_s[c], pop_acc_s[c]})
        2'b10:   count_d[c] = count_q[c] + ONE_CNT;
        2'b01:   count_d[c] = count_q[c] - ONE_CNT;
        default: count_d[c] = count_q[c];
      endcase
      if ((push_s[c] & ~push_acc_s[c]) | (pop_s[c] & empty_s[c])) begin
        error_d = 1'b1;
      end else begin
        error_d = error_d;
      end
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      for (int c = 0; c < 2; c++) begin
        rd_ptr_q[c] <= {PTR_WIDTH{1'b0}};
        wr_ptr_q[c] <= {PTR_WIDTH{1'b0}};
        count_q[c]  <= {(PTR_WIDTH + 1){1'b0}};
        out_q[c]    <= {DATA_WIDTH{1'b0}};
      end
      valid_q <= 2'b00;
      error_q <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        rd_ptr_q[c] <= rd_ptr_d[c];
        wr_ptr_q[c] <= wr_ptr_d[c];
        count_q[c]  <= count_d[c];
        out_q[c]    <= out_d[c];
      end
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  // Storage array; contents are never read before being written, so no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.D0_out          = out_q[0];
  assign bus.D1_out          = out_q[1];
  assign bus.D0_valid        = valid_q[0];
  assign bus.D1_valid        = valid_q[1];
  assign bus.D0_pause        = pause_s[0];
  assign bus.D1_pause        = pause_s[1];
  assign bus.D0_empty        = empty_s[0];
  assign bus.D1_empty        = empty_s[1];
  assign bus.D0_full         = full_s[0];
  assign bus.D1_full         = full_s[1];
  assign bus.D0_almost_empty = ae_s[0];
  assign bus.D1_almost_empty = ae_s[1];
  assign bus.error_out       = error_q;

endmodule

// File: tb/tb_fifos_destino_d0_d1.sv
// Scoreboard bench for the D0/D1 destination FIFOs: directed pushes/pops, expected
// read words queued at pop time and checked by an independent read-port monitor.
module tb_fifos_destino_d0_d1;

  typedef struct {
    logic [5:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_L;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  fifos_destino_d0_d1_if #(.DATA_WIDTH(6)) bus ();

  fifos_destino_d0_d1 dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p0, input logic [5:0] d0, input logic r0,
                       input logic p1, input logic [5:0] d1, input logic r1);
    bus.D0_push = p0; bus.arbitro_D0_out = d0; bus.D0_pop = r0;
    bus.D1_push = p1; bus.arbitro_D1_out = d1; bus.D1_pop = r1;
    @(negedge clk);
  endtask

  task automatic expect_rd(input int ch, input logic [5:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + 1;
    if (ch == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  // Read-port monitor: every valid must match the oldest expected word and its cycle
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.D0_valid === 1'b1) begin
        total++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL d0_unexpected_valid: got data %0h, want no valid", bus.D0_out);
        end else begin
          e = q0.pop_front();
          if (bus.D0_out !== e.data || cyc != e.cyc) begin
            bad++;
            $display("FAIL d0_read: got data %0h at cycle %0d, want %0h at cycle %0d",
                     bus.D0_out, cyc, e.data, e.cyc);
          end
        end
      end else if (q0.size() != 0 && q0[0].cyc <= cyc) begin
        total++; bad++;
        e = q0.pop_front();
        $display("FAIL d0_missing_valid: got valid 0 at cycle %0d, want data %0h", cyc, e.data);
      end
      if (bus.D1_valid === 1'b1) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL d1_unexpected_valid: got data %0h, want no valid", bus.D1_out);
        end else begin
          e = q1.pop_front();
          if (bus.D1_out !== e.data || cyc != e.cyc) begin
            bad++;
            $display("FAIL d1_read: got data %0h at cycle %0d, want %0h at cycle %0d",
                     bus.D1_out, cyc, e.data, e.cyc);
          end
        end
      end else if (q1.size() != 0 && q1[0].cyc <= cyc) begin
        total++; bad++;
        e = q1.pop_front();
        $display("FAIL d1_missing_valid: got valid 0 at cycle %0d, want data %0h", cyc, e.data);
      end
    end
  end

  initial begin
    reset_L = 1'b0;
    @(negedge clk);
    // Reset with every request held high
    repeat (3) drive(1'b1, 6'h15, 1'b1, 1'b1, 6'h2A, 1'b1);
    chk("rst_d0_empty", bus.D0_empty, 1'b1);
    chk("rst_d1_empty", bus.D1_empty, 1'b1);
    chk("rst_d0_out",   bus.D0_out,   6'h00);
    chk("rst_d1_out",   bus.D1_out,   6'h00);
    chk("rst_d0_valid", bus.D0_valid, 1'b0);
    chk("rst_d1_valid", bus.D1_valid, 1'b0);
    chk("rst_d0_pause", bus.D0_pause, 1'b0);
    chk("rst_d1_full",  bus.D1_full,  1'b0);
    chk("rst_d0_ae",    bus.D0_almost_empty, 1'b1);
    chk("rst_error",    bus.error_out, 1'b0);
    reset_L = 1'b1;
    mon_en  = 1'b1;
    drive(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0);
    chk("post_rst_d0_empty", bus.D0_empty, 1'b1);

    // Fill D0 with 01..08, then overflow with 09
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 6'(i), 1'b0, 1'b0, 6'h00, 1'b0);
      chk("fill_d0_pause", bus.D0_pause, (i >= 6));
      chk("fill_d0_full",  bus.D0_full,  (i == 8));
      chk("fill_d0_ae",    bus.D0_almost_empty, (i <= 1));
      chk("fill_error",    bus.error_out, 1'b0);
    end
    drive(1'b1, 6'h09, 1'b0, 1'b0, 6'h00, 1'b0);
    chk("ovf_error",   bus.error_out, 1'b1);
    chk("ovf_d0_full", bus.D0_full,   1'b1);

    // Drain D0; 09 must not appear
    for (int i = 1; i <= 8; i++) begin
      expect_rd(0, 6'(i));
      drive(1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b0);
      chk("drain_d0_empty", bus.D0_empty, (i == 8));
      chk("drain_d0_pause", bus.D0_pause, ((8 - i) >= 6));
    end
    drive(1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b0);
    drive(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0);
    chk("udf_d0_out_hold", bus.D0_out,    6'h08);
    chk("udf_error",       bus.error_out, 1'b1);
    chk("udf_d0_empty",    bus.D0_empty,  1'b1);

    // Reset clears the sticky error
    reset_L = 1'b0;
    drive(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0);
    reset_L = 1'b1;
    drive(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0);
    chk("rst2_error", bus.error_out, 1'b0);

    // Pointer wrap: 5 in/out, then 6 in/out across 7->0
    for (int i = 0; i < 5; i++) drive(1'b1, 6'(6'h10 + i), 1'b0, 1'b0, 6'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      expect_rd(0, 6'(6'h10 + i));
      drive(1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b0);
    end
    for (int i = 0; i < 6; i++) drive(1'b1, 6'(6'h20 + i), 1'b0, 1'b0, 6'h00, 1'b0);
    chk("wrap_d0_pause", bus.D0_pause, 1'b1);
    for (int i = 0; i < 6; i++) begin
      expect_rd(0, 6'(6'h20 + i));
      drive(1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b0);
    end
    chk("wrap_d0_empty", bus.D0_empty,  1'b1);
    chk("wrap_error",    bus.error_out, 1'b0);

    // Full FIFO with simultaneous push 2A and pop
    for (int i = 0; i < 8; i++) drive(1'b1, 6'(6'h30 + i), 1'b0, 1'b0, 6'h00, 1'b0);
    chk("full_d0_full", bus.D0_full, 1'b1);
    expect_rd(0, 6'h30);
    drive(1'b1, 6'h2A, 1'b1, 1'b0, 6'h00, 1'b0);
    chk("recycle_d0_full", bus.D0_full,   1'b1);
    chk("recycle_error",   bus.error_out, 1'b0);
    for (int i = 1; i < 8; i++) begin
      expect_rd(0, 6'(6'h30 + i));
      drive(1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b0);
    end
    expect_rd(0, 6'h2A);
    drive(1'b0, 6'h00, 1'b1, 1'b0, 6'h00, 1'b0);
    chk("recycle_d0_empty", bus.D0_empty,  1'b1);
    chk("recycle_error2",   bus.error_out, 1'b0);

    // Independence: D0 paused at 6 words while D1 streams
    for (int i = 0; i < 6; i++) drive(1'b1, 6'(6'h01 + i), 1'b0, 1'b0, 6'h00, 1'b0);
    chk("ind_d0_pause", bus.D0_pause, 1'b1);
    drive(1'b0, 6'h00, 1'b0, 1'b1, 6'h05, 1'b0);
    chk("ind_d1_empty", bus.D1_empty, 1'b0);
    chk("ind_d1_ae",    bus.D1_almost_empty, 1'b1);
    chk("ind_d1_pause", bus.D1_pause, 1'b0);
    expect_rd(1, 6'h05);
    drive(1'b0, 6'h00, 1'b0, 1'b1, 6'h06, 1'b1);
    chk("ind_d1_ae2", bus.D1_almost_empty, 1'b1);
    expect_rd(1, 6'h06);
    drive(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b1);
    chk("ind_d1_empty2",  bus.D1_empty, 1'b1);
    chk("ind_d0_pause2",  bus.D0_pause, 1'b1);
    chk("ind_d0_empty",   bus.D0_empty, 1'b0);
    chk("ind_error",      bus.error_out, 1'b0);

    // Push and pop together at empty: pop rejected, push stored
    drive(1'b0, 6'h00, 1'b0, 1'b1, 6'h3F, 1'b1);
    chk("emptypp_d1_empty", bus.D1_empty,  1'b0);
    chk("emptypp_error",    bus.error_out, 1'b1);
    expect_rd(1, 6'h3F);
    drive(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b1);
    chk("emptypp_d1_empty2", bus.D1_empty, 1'b1);

    // Mid-stream reset with requests held high
    reset_L = 1'b0;
    drive(1'b1, 6'h0A, 1'b1, 1'b1, 6'h0B, 1'b1);
    chk("mid_d0_empty", bus.D0_empty, 1'b1);
    chk("mid_d1_empty", bus.D1_empty, 1'b1);
    chk("mid_d0_pause", bus.D0_pause, 1'b0);
    chk("mid_d0_valid", bus.D0_valid, 1'b0);
    chk("mid_d1_valid", bus.D1_valid, 1'b0);
    chk("mid_error",    bus.error_out, 1'b0);
    reset_L = 1'b1;
    drive(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0);
    chk("mid_d0_empty2", bus.D0_empty, 1'b1);
    chk("mid_d1_empty2", bus.D1_empty, 1'b1);

    repeat (2) drive(1'b0, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0);
    chk("d0_reads_outstanding", q0.size(), 0);
    chk("d1_reads_outstanding", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
